// File: rtl/gate_round_sequencer.sv
// Gate round sequencer: picks random target gates, scores hits and misses,
// blanks the display on a miss and reports win/lose to the game top level.
module gate_round_sequencer #(
  parameter int NUM_GATES    = 8,
  parameter int BLANK_CYCLES = 25000000,
  parameter int MAX_MISSES   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 confirm,
  input  logic [NUM_GATES-1:0] selected_gate,
  output logic [NUM_GATES-1:0] current_gate,
  output logic [NUM_GATES-1:0] completed_gate,
  output logic                 timer_en,
  output logic                 timer_clear,
  output logic                 vga_blankout,
  output logic [1:0]           miss_count,
  output logic                 done,
  output logic                 game_over
);

  localparam int PW = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
  localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(NUM_GATES - 1);
  localparam logic [1:0]    MISS_LIMIT = 2'(MAX_MISSES);
  localparam logic [NUM_GATES-1:0] GATE_ONE = NUM_GATES'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_PLAY,
    S_BLANK,
    S_WIN,
    S_LOSE
  } state_t;

  state_t               r_state;
  logic [7:0]           r_lfsr;
  logic [PW-1:0]        r_ptr;
  logic [CW-1:0]        r_blank_cnt;
  logic [NUM_GATES-1:0] r_cur;
  logic [NUM_GATES-1:0] r_comp;
  logic [1:0]           r_miss;
  logic                 r_ten;
  logic                 r_tclr;
  logic                 r_vga;
  logic                 r_done;
  logic                 r_over;

  state_t               w_state;
  logic [7:0]           w_lfsr;
  logic [PW-1:0]        w_ptr;
  logic [CW-1:0]        w_blank_cnt;
  logic [NUM_GATES-1:0] w_cur;
  logic [NUM_GATES-1:0] w_comp;
  logic [1:0]           w_miss;
  logic                 w_ten;
  logic                 w_tclr;
  logic                 w_vga;
  logic                 w_done;
  logic                 w_over;

  logic                 w_fb;
  logic [PW-1:0]        w_seed_ptr;
  logic [PW-1:0]        w_ptr_inc;
  logic                 w_ptr_taken;
  logic                 w_hit;
  logic [NUM_GATES-1:0] w_comp_hit;
  logic [1:0]           w_miss_inc;

  // Helper terms: LFSR feedback, scan pointer arithmetic, hit detection.
  always_comb begin
    w_fb        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    w_seed_ptr  = PW'(int'(r_lfsr[2:0]) % NUM_GATES);
    w_ptr_inc   = (r_ptr == PTR_LAST) ? '0 : r_ptr + PW'(1);
    w_ptr_taken = r_comp[r_ptr];
    w_hit       = (selected_gate == r_cur);
    w_comp_hit  = r_comp | r_cur;
    w_miss_inc  = r_miss + 2'd1;
  end

  // Next-state and next-output decode; every output is a register.
  always_comb begin
    w_state     = r_state;
    w_lfsr      = {r_lfsr[6:0], w_fb};
    w_ptr       = r_ptr;
    w_blank_cnt = r_blank_cnt;
    w_cur       = r_cur;
    w_comp      = r_comp;
    w_miss      = r_miss;
    w_ten       = r_ten;
    w_tclr      = 1'b0;
    w_vga       = r_vga;
    w_done      = r_done;
    w_over      = r_over;
    case (r_state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          w_state = S_PICK;
          w_ptr   = w_seed_ptr;
          w_cur   = '0;
          w_comp  = '0;
          w_miss  = 2'd0;
          w_ten   = 1'b1;
          w_tclr  = 1'b1;
          w_vga   = 1'b0;
          w_done  = 1'b0;
          w_over  = 1'b0;
        end
      end
      S_PICK: begin
        if (!w_ptr_taken) begin
          w_state = S_PLAY;
          w_cur   = GATE_ONE << r_ptr;
        end else begin
          w_ptr = w_ptr_inc;
        end
      end
      S_PLAY: begin
        if (confirm) begin
          if (w_hit) begin
            w_comp = w_comp_hit;
            w_cur  = '0;
            if (&w_comp_hit) begin
              w_state = S_WIN;
              w_ten   = 1'b0;
              w_done  = 1'b1;
            end else begin
              w_state = S_PICK;
              w_ptr   = w_seed_ptr;
            end
          end else begin
            w_miss = w_miss_inc;
            if (w_miss_inc == MISS_LIMIT) begin
              w_state = S_LOSE;
              w_cur   = '0;
              w_ten   = 1'b0;
              w_over  = 1'b1;
            end else begin
              w_state     = S_BLANK;
              w_blank_cnt = BLANK_LOAD;
              w_vga       = 1'b1;
            end
          end
        end
      end
      S_BLANK: begin
        if (r_blank_cnt == '0) begin
          w_state = S_PLAY;
          w_vga   = 1'b0;
        end else begin
          w_blank_cnt = r_blank_cnt - CW'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lfsr      <= 8'h01;
      r_ptr       <= '0;
      r_blank_cnt <= '0;
      r_cur       <= '0;
      r_comp      <= '0;
      r_miss      <= 2'd0;
      r_ten       <= 1'b0;
      r_tclr      <= 1'b0;
      r_vga       <= 1'b0;
      r_done      <= 1'b0;
      r_over      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_lfsr      <= w_lfsr;
      r_ptr       <= w_ptr;
      r_blank_cnt <= w_blank_cnt;
      r_cur       <= w_cur;
      r_comp      <= w_comp;
      r_miss      <= w_miss;
      r_ten       <= w_ten;
      r_tclr      <= w_tclr;
      r_vga       <= w_vga;
      r_done      <= w_done;
      r_over      <= w_over;
    end
  end

  assign current_gate   = r_cur;
  assign completed_gate = r_comp;
  assign timer_en       = r_ten;
  assign timer_clear    = r_tclr;
  assign vga_blankout   = r_vga;
  assign miss_count     = r_miss;
  assign done           = r_done;
  assign game_over      = r_over;

endmodule

// File: tb/tb_gate_round_sequencer.sv
// Directed bench for gate_round_sequencer with a short blackout.
// Target gates are predicted from a reference LFSR and a scan model.
module tb_gate_round_sequencer;

  localparam int N  = 8;
  localparam int BC = 4;
  localparam int MM = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         confirm;
  logic [N-1:0] selected_gate;
  logic [N-1:0] current_gate;
  logic [N-1:0] completed_gate;
  logic         timer_en;
  logic         timer_clear;
  logic         vga_blankout;
  logic [1:0]   miss_count;
  logic         done;
  logic         game_over;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_lfsr;

  gate_round_sequencer #(
    .NUM_GATES   (N),
    .BLANK_CYCLES(BC),
    .MAX_MISSES  (MM)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .confirm       (confirm),
    .selected_gate (selected_gate),
    .current_gate  (current_gate),
    .completed_gate(completed_gate),
    .timer_en      (timer_en),
    .timer_clear   (timer_clear),
    .vga_blankout  (vga_blankout),
    .miss_count    (miss_count),
    .done          (done),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  // Reference x^8+x^6+x^5+x^4+1 LFSR, seed 01, steps every clock.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'h01;
    else m_lfsr <= {m_lfsr[6:0],
                    m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [7:0] exp_pick(input logic [7:0] mask,
                                          input logic [2:0] p);
    logic [7:0] r;
    logic [2:0] idx;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      idx = p + 3'(k);
      if (!mask[idx] && r == 8'h00) r = 8'h01 << idx;
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_play(output int n);
    n = 0;
    while (current_gate == '0 && n < 12) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_unblank(output int n);
    n = 0;
    while (vga_blankout && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    logic [23:0] o;
    reset = 1'b1; start = 1'b1; confirm = 1'b1;
    selected_gate = 8'hFF;
    tick(); tick();
    o = {current_gate, completed_gate, timer_en, timer_clear,
         vga_blankout, miss_count, done, game_over};
    checks++;
    if (o !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", o);
    end
    reset = 1'b0; start = 1'b0; confirm = 1'b0;
    selected_gate = '0;
    tick();
    checks++;
    if (timer_en !== 1'b0 || current_gate !== '0) begin
      errors++;
      $display("FAIL idle_after_reset ten=%b cur=%h want 0/00",
               timer_en, current_gate);
    end
  endtask

  task automatic test_start;
    logic [7:0] lf;
    logic [7:0] want;
    lf = m_lfsr;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (timer_clear !== 1'b1 || timer_en !== 1'b1) begin
      errors++;
      $display("FAIL start_timer tclr=%b ten=%b want 1/1",
               timer_clear, timer_en);
    end
    checks++;
    if (current_gate !== '0 || completed_gate !== '0 ||
        miss_count !== 2'd0 || done !== 1'b0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL start_pick cur=%h comp=%h miss=%0d want 0",
               current_gate, completed_gate, miss_count);
    end
    tick();
    want = 8'h01 << lf[2:0];
    checks++;
    if (timer_clear !== 1'b0) begin
      errors++;
      $display("FAIL tclr_pulse got=%b want=0", timer_clear);
    end
    checks++;
    if (current_gate !== want || timer_en !== 1'b1) begin
      errors++;
      $display("FAIL first_target got=%h want=%h ten=%b",
               current_gate, want, timer_en);
    end
  endtask

  task automatic test_hit;
    logic [7:0] g;
    logic [7:0] mask;
    logic [7:0] lf;
    int n;
    g = current_gate; mask = completed_gate; lf = m_lfsr;
    selected_gate = g; confirm = 1'b1;
    tick();
    confirm = 1'b0; selected_gate = '0;
    checks++;
    if (completed_gate !== (mask | g) || current_gate !== '0) begin
      errors++;
      $display("FAIL hit_mark comp=%h want=%h cur=%h want=00",
               completed_gate, mask | g, current_gate);
    end
    wait_play(n);
    checks++;
    if (n < 1 || n > N) begin
      errors++;
      $display("FAIL hit_pick_latency got=%0d want=1..%0d", n, N);
    end
    checks++;
    if (current_gate !== exp_pick(mask | g, lf[2:0]) ||
        (current_gate & completed_gate) !== '0) begin
      errors++;
      $display("FAIL hit_next got=%h want=%h",
               current_gate, exp_pick(mask | g, lf[2:0]));
    end
  endtask

  task automatic test_blank;
    logic [7:0] g;
    logic [7:0] mask;
    int hi;
    g = current_gate; mask = completed_gate;
    selected_gate = '0; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    checks++;
    if (vga_blankout !== 1'b1 || miss_count !== 2'd1 ||
        current_gate !== g || timer_en !== 1'b1) begin
      errors++;
      $display("FAIL miss_enter vga=%b miss=%0d cur=%h ten=%b want 1/1/%h/1",
               vga_blankout, miss_count, current_gate, timer_en, g);
    end
    hi = 1;
    start = 1'b1; confirm = 1'b1; selected_gate = g;
    tick();
    start = 1'b0; confirm = 1'b0; selected_gate = '0;
    if (vga_blankout) hi++;
    checks++;
    if (timer_clear !== 1'b0 || completed_gate !== mask) begin
      errors++;
      $display("FAIL blank_ignores tclr=%b comp=%h want 0/%h",
               timer_clear, completed_gate, mask);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vga_blankout) hi++;
      else break;
    end
    checks++;
    if (hi !== BC) begin
      errors++;
      $display("FAIL blank_len got=%0d want=%0d", hi, BC);
    end
    checks++;
    if (current_gate !== g || miss_count !== 2'd1 ||
        completed_gate !== mask || timer_en !== 1'b1) begin
      errors++;
      $display("FAIL blank_exit cur=%h miss=%0d comp=%h want %h/1/%h",
               current_gate, miss_count, completed_gate, g, mask);
    end
  endtask

  task automatic test_lose;
    logic [7:0] g;
    logic [7:0] mask;
    int n;
    g = current_gate; mask = completed_gate;
    selected_gate = g | {g[6:0], g[7]}; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    checks++;
    if (miss_count !== 2'd2 || vga_blankout !== 1'b1) begin
      errors++;
      $display("FAIL miss2 miss=%0d vga=%b want 2/1",
               miss_count, vga_blankout);
    end
    wait_unblank(n);
    checks++;
    if (n !== BC || current_gate !== g) begin
      errors++;
      $display("FAIL miss2_blank len=%0d cur=%h want %0d/%h",
               n, current_gate, BC, g);
    end
    selected_gate = ~g; confirm = 1'b1;
    tick();
    confirm = 1'b0; selected_gate = '0;
    checks++;
    if (game_over !== 1'b1 || timer_en !== 1'b0 || current_gate !== '0 ||
        miss_count !== 2'd3 || vga_blankout !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL lose over=%b ten=%b cur=%h miss=%0d vga=%b done=%b",
               game_over, timer_en, current_gate, miss_count,
               vga_blankout, done);
    end
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    checks++;
    if (miss_count !== 2'd3 || game_over !== 1'b1 ||
        completed_gate !== mask) begin
      errors++;
      $display("FAIL lose_hold miss=%0d over=%b comp=%h want 3/1/%h",
               miss_count, game_over, completed_gate, mask);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (miss_count !== 2'd0 || completed_gate !== '0 ||
        game_over !== 1'b0 || timer_clear !== 1'b1 || timer_en !== 1'b1) begin
      errors++;
      $display("FAIL restart miss=%0d comp=%h over=%b tclr=%b ten=%b",
               miss_count, completed_gate, game_over, timer_clear, timer_en);
    end
  endtask

  task automatic test_win;
    logic [7:0] g;
    logic [7:0] mask;
    logic [7:0] lf;
    int n;
    wait_play(n);
    checks++;
    if (n < 1 || n > N || $countones(current_gate) != 1) begin
      errors++;
      $display("FAIL win_first lat=%0d cur=%h", n, current_gate);
    end
    for (int i = 0; i < N; i++) begin
      g = current_gate; mask = completed_gate; lf = m_lfsr;
      checks++;
      if ($countones(g) != 1 || (g & mask) !== '0) begin
        errors++;
        $display("FAIL win_target i=%0d cur=%h comp=%h", i, g, mask);
      end
      selected_gate = g; confirm = 1'b1;
      tick();
      confirm = 1'b0; selected_gate = '0;
      checks++;
      if (completed_gate !== (mask | g)) begin
        errors++;
        $display("FAIL win_mark i=%0d got=%h want=%h",
                 i, completed_gate, mask | g);
      end
      if (i < N - 1) begin
        wait_play(n);
        checks++;
        if (current_gate !== exp_pick(mask | g, lf[2:0])) begin
          errors++;
          $display("FAIL win_scan i=%0d got=%h want=%h", i,
                   current_gate, exp_pick(mask | g, lf[2:0]));
        end
      end
    end
    checks++;
    if (done !== 1'b1 || timer_en !== 1'b0 || current_gate !== '0 ||
        completed_gate !== 8'hFF || game_over !== 1'b0) begin
      errors++;
      $display("FAIL win done=%b ten=%b cur=%h comp=%h over=%b",
               done, timer_en, current_gate, completed_gate, game_over);
    end
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    checks++;
    if (done !== 1'b1 || completed_gate !== 8'hFF || miss_count !== 2'd0) begin
      errors++;
      $display("FAIL win_hold done=%b comp=%h miss=%0d",
               done, completed_gate, miss_count);
    end
  endtask

  task automatic test_reset_blank;
    logic [23:0] o;
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || completed_gate !== '0) begin
      errors++;
      $display("FAIL win_restart done=%b comp=%h want 0/00",
               done, completed_gate);
    end
    wait_play(n);
    selected_gate = '0; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tick();
    checks++;
    if (vga_blankout !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_blank vga=%b want 1", vga_blankout);
    end
    reset = 1'b1; start = 1'b1; confirm = 1'b1;
    selected_gate = current_gate;
    tick();
    reset = 1'b0; start = 1'b0; confirm = 1'b0;
    selected_gate = '0;
    o = {current_gate, completed_gate, timer_en, timer_clear,
         vga_blankout, miss_count, done, game_over};
    checks++;
    if (o !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid_blank got=%h want=0", o);
    end
    tick(); tick();
    checks++;
    if (timer_en !== 1'b0 || vga_blankout !== 1'b0 ||
        current_gate !== '0) begin
      errors++;
      $display("FAIL idle_after_mid_reset ten=%b vga=%b cur=%h",
               timer_en, vga_blankout, current_gate);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit();
    test_blank();
    test_lose();
    test_win();
    test_reset_blank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
